set_assoc_cache: RTL and testbench

Parametrised N-way set-associative read cache with LRU replacement. It is the successor to the direct-mapped data cache and sits between the requesting core/bench and the word-addressed main memory. Words are returned on the same `req`/`ready` handshake as before. Misses fetch one full block over a request/ready memory port. A saturating hit counter and a saturating access counter are exposed for hit-rate measurement.

---
 rtl/set_assoc_cache.sv | 161 ++++++++++++++++
 tb/tb_set_assoc_cache.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative read cache with LRU replacement and block fill
module set_assoc_cache #(
    parameter int WORD        = 32,
    parameter int ADDRESSL    = 15,
    parameter int WAYS        = 2,
    parameter int SETS        = 128,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic [ADDRESSL-1:0]         address,
    input  logic                        flush,
    output logic [WORD-1:0]             dataOut,
    output logic                        ready,
    output logic [ADDRESSL-1:0]         numOfHits,
    output logic [ADDRESSL-1:0]         numOfAccesses,
    output logic                        memReq,
    output logic [ADDRESSL-1:0]         memAddress,
    input  logic [BLOCK_WORDS*WORD-1:0] memData,
    input  logic                        memReady
);
    localparam int OFF = $clog2(BLOCK_WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDRESSL - IDX - OFF;
    localparam int OW  = (OFF > 0) ? OFF : 1;
    localparam int IW  = (IDX > 0) ? IDX : 1;
    localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, TAGRD, LOOKUP, MISS} state_t;
    state_t state, state_d;

    logic [TAG-1:0]              tags  [SETS][WAYS];
    logic [BLOCK_WORDS*WORD-1:0] data  [SETS][WAYS];
    logic [AW-1:0]               age   [SETS][WAYS];
    logic [WAYS-1:0]             valid [SETS];

    logic [ADDRESSL-1:0] addr_q;
    logic                hit_q;
    logic [AW-1:0]       hway_q, victim_q;
    logic [TAG-1:0]      tag;
    logic [IW-1:0]       idx;
    logic [OW-1:0]       off;
    logic                tag_hit, vict_found, lru_upd;
    logic [AW-1:0]       hit_way, vict_way, lru_way;

    assign off = OW'(addr_q) & OW'(BLOCK_WORDS - 1);
    assign idx = IW'(addr_q >> OFF) & IW'(SETS - 1);
    assign tag = TAG'(addr_q >> (OFF + IDX));

    assign ready  = (state == IDLE);
    assign memReq = (state == MISS);

    // Victim prefers the lowest invalid way; otherwise the oldest (age WAYS-1).
    always_comb begin
        tag_hit    = 1'b0;
        hit_way    = '0;
        vict_way   = '0;
        vict_found = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            if (valid[idx][j] && tags[idx][j] == tag) begin
                tag_hit = 1'b1;
                hit_way = AW'(j);
            end
            if (!valid[idx][j] && !vict_found) begin
                vict_found = 1'b1;
                vict_way   = AW'(j);
            end
        end
        if (!vict_found) begin
            for (int j = 0; j < WAYS; j++) begin
                if (age[idx][j] == AW'(WAYS - 1)) vict_way = AW'(j);
            end
        end
    end

    always_comb begin
        state_d = state;
        lru_upd = 1'b0;
        lru_way = victim_q;
        case (state)
            IDLE:   if (!flush && req) state_d = TAGRD;
            TAGRD:  state_d = LOOKUP;
            LOOKUP: begin
                state_d = hit_q ? IDLE : MISS;
                lru_upd = hit_q;
                lru_way = hway_q;
            end
            MISS: if (memReady) begin
                state_d = IDLE;
                lru_upd = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            hit_q         <= 1'b0;
            hway_q        <= '0;
            victim_q      <= '0;
            dataOut       <= '0;
            memAddress    <= '0;
            numOfHits     <= '0;
            numOfAccesses <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int j = 0; j < WAYS; j++) age[s][j] <= AW'(j);
            end
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) valid[s] <= '0;
                    end else if (req) begin
                        addr_q <= address;
                        if (numOfAccesses != '1) numOfAccesses <= numOfAccesses + 1'b1;
                    end
                end
                TAGRD: begin
                    hit_q    <= tag_hit;
                    hway_q   <= hit_way;
                    victim_q <= vict_way;
                end
                LOOKUP: begin
                    if (hit_q) begin
                        dataOut <= data[idx][hway_q][int'(off)*WORD +: WORD];
                        if (numOfHits != '1) numOfHits <= numOfHits + 1'b1;
                    end else begin
                        memAddress <= addr_q & ~ADDRESSL'(BLOCK_WORDS - 1);
                    end
                end
                MISS: begin
                    if (memReady) begin
                        valid[idx][victim_q] <= 1'b1;
                        dataOut <= memData[int'(off)*WORD +: WORD];
                    end
                end
                default: ;
            endcase
            // Ages younger than the touched way shift up by one; the touched way becomes 0.
            if (lru_upd) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (AW'(j) == lru_way) age[idx][j] <= '0;
                    else if (age[idx][j] < age[idx][lru_way]) age[idx][j] <= age[idx][j] + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && state == MISS && memReady) begin
            data[idx][victim_q] <= memData;
            tags[idx][victim_q] <= tag;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - scoreboard bench for set_assoc_cache
module tb_set_assoc_cache;
    logic         clk = 1'b0;
    logic         rst, req, flush, memReady;
    logic [14:0]  address;
    logic [31:0]  dataOut;
    logic         ready, memReq;
    logic [14:0]  numOfHits, numOfAccesses, memAddress;
    logic [127:0] memData;

    logic         rst2, req2, memReady2, ready2, memReq2;
    logic [7:0]   address2, hits2, acc2, memAddress2;
    logic [31:0]  dataOut2;
    logic [127:0] memData2;

    int nchk = 0, nerr = 0;
    int fills = 0;
    logic [14:0] last_maddr = '0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk(clk), .rst(rst), .req(req), .address(address), .flush(flush),
        .dataOut(dataOut), .ready(ready), .numOfHits(numOfHits),
        .numOfAccesses(numOfAccesses), .memReq(memReq), .memAddress(memAddress),
        .memData(memData), .memReady(memReady)
    );

    set_assoc_cache #(.WORD(32), .ADDRESSL(8), .WAYS(2), .SETS(4), .BLOCK_WORDS(4)) dut_sat (
        .clk(clk), .rst(rst2), .req(req2), .address(address2), .flush(1'b0),
        .dataOut(dataOut2), .ready(ready2), .numOfHits(hits2),
        .numOfAccesses(acc2), .memReq(memReq2), .memAddress(memAddress2),
        .memData(memData2), .memReady(memReady2)
    );

    function automatic logic [31:0] mword(input logic [14:0] a);
        logic [14:0] base;
        base = {a[14:2], 2'b00};
        return 32'hA000_0000 + 32'(base) * 2 + 32'(a[1:0]);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: answers a held memReq after 5 cycles with a one-cycle memReady pulse.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        memReady = 1'b0;
        memData  = '0;
        forever begin
            @(negedge clk);
            memReady = 1'b0;
            if (memReq) begin
                wait_cnt++;
                if (wait_cnt == 5) begin
                    for (int k = 0; k < 4; k++)
                        memData[k*32 +: 32] = mword(memAddress + 15'(k));
                    last_maddr = memAddress;
                    memReady = 1'b1;
                    fills++;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        memReady2 = 1'b0;
        memData2  = {4{32'h5A5A_0000}};
        forever begin
            @(negedge clk);
            memReady2 = memReq2;
        end
    end

    // Small instance: req held on one address to drive both counters into saturation.
    initial begin
        rst2 = 1'b1; req2 = 1'b0; address2 = 8'h00;
        repeat (2) @(negedge clk);
        rst2 = 1'b0; req2 = 1'b1;
    end

    task automatic do_access(input logic [14:0] a, output bit missed, output int lat);
        int n, f0;
        n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        address = a;
        req = 1'b1;
        sb_q.push_back(mword(a));
        f0 = fills;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) check("access_timeout", 64'(lat), 64'(0));
        check("data", 64'(dataOut), 64'(sb_q.pop_front()));
        missed = (fills != f0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit missed;
        int lat, guard, done;
        logic [14:0] h0, nxt;
        int f0;
        rst = 1'b1; req = 1'b0; flush = 1'b0; address = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", 64'(ready), 64'(1));
        check("rst_data", 64'(dataOut), 64'(0));
        check("rst_memreq", 64'(memReq), 64'(0));
        check("rst_memaddr", 64'(memAddress), 64'(0));
        check("rst_hits", 64'(numOfHits), 64'(0));
        check("rst_acc", 64'(numOfAccesses), 64'(0));

        do_access(15'd1024, missed, lat);
        check("cold_miss", 64'(missed), 64'(1));
        check("cold_memaddr", 64'(last_maddr), 64'(1024));
        check("cold_hits", 64'(numOfHits), 64'(0));
        check("cold_acc", 64'(numOfAccesses), 64'(1));
        do_access(15'd1025, missed, lat);
        check("hit_1025", 64'(missed), 64'(0));
        check("hit_latency", 64'(lat), 64'(2));
        check("hit_count", 64'(numOfHits), 64'(1));

        do_reset();
        do_access(15'd1024, missed, lat);
        check("lru_a", 64'(missed), 64'(1));
        do_access(15'd1536, missed, lat);
        check("lru_b", 64'(missed), 64'(1));
        do_access(15'd1024, missed, lat);
        check("lru_a_hit", 64'(missed), 64'(0));
        do_access(15'd2048, missed, lat);
        check("lru_c", 64'(missed), 64'(1));
        do_access(15'd1024, missed, lat);
        check("lru_a_kept", 64'(missed), 64'(0));
        do_access(15'd1536, missed, lat);
        check("lru_b_evicted", 64'(missed), 64'(1));
        check("lru_b_memaddr", 64'(last_maddr), 64'(1536));

        do_access(15'd1024, missed, lat);
        h0 = numOfHits;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_hits", 64'(numOfHits), 64'(h0));
        do_access(15'd1024, missed, lat);
        check("flush_miss", 64'(missed), 64'(1));
        check("flush_hits_after", 64'(numOfHits), 64'(h0));

        address = 15'd3000;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        guard = 0;
        while (!memReq && guard < 20) begin @(negedge clk); guard++; end
        check("mid_memreq_seen", 64'(memReq), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_memreq", 64'(memReq), 64'(0));
        check("mid_ready", 64'(ready), 64'(1));
        check("mid_hits", 64'(numOfHits), 64'(0));
        check("mid_acc", 64'(numOfAccesses), 64'(0));
        repeat (8) @(negedge clk);
        check("mid_data_held", 64'(dataOut), 64'(0));
        do_access(15'd3000, missed, lat);
        check("mid_refetch", 64'(missed), 64'(1));

        do_reset();
        f0 = fills;
        address = 15'd1024;
        req = 1'b1;
        sb_q.push_back(mword(15'd1024));
        nxt = 15'd1025;
        done = 0;
        guard = 0;
        while (done < 8192 && guard < 60000) begin
            @(negedge clk);
            guard++;
            if (ready) begin
                check("sweep_data", 64'(dataOut), 64'(sb_q.pop_front()));
                done++;
                if (nxt <= 15'd9215) begin
                    address = nxt;
                    sb_q.push_back(mword(nxt));
                    nxt++;
                end else begin
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        check("sweep_done", 64'(done), 64'(8192));
        check("sweep_fills", 64'(fills - f0), 64'(2048));
        check("sweep_hits", 64'(numOfHits), 64'(6144));
        check("sweep_acc", 64'(numOfAccesses), 64'(8192));

        check("sat_hits", 64'(hits2), 64'(255));
        check("sat_acc", 64'(acc2), 64'(255));
        repeat (30) @(negedge clk);
        check("sat_hits_hold", 64'(hits2), 64'(255));
        check("sat_data", 64'(dataOut2), 64'(32'h5A5A_0000));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
